// File: rtl/zigzag_pp.sv
// zigzag_pp: 8x8 coefficient reorder stage with a two-bank ping-pong buffer, emitting
// OUT_LANES coefficients per beat in zigzag or raster order. Define ZIGZAG_EOB_EN for zig_eob_o.
module zigzag_pp #(
  parameter int ZIG_IN_WIDTH  = 16,
  parameter int ZIG_OUT_WIDTH = 16,
  parameter int OUT_LANES     = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               zig_go_i,
  input  logic                               zig_mode_i,
  input  logic [ZIG_IN_WIDTH*8-1:0]          zig_in_i,
  output logic                               zig_free_o,
  output logic                               zig_ovf_o,
  output logic                               zig_vld_o,
  input  logic                               zig_rdy_i,
  output logic [ZIG_OUT_WIDTH*OUT_LANES-1:0] zig_out_o,
  output logic                               zig_first_o,
  output logic                               zig_last_o
`ifdef ZIGZAG_EOB_EN
  ,
  output logic [6:0]                         zig_eob_o
`endif
);

  localparam int BEATS = 64 / OUT_LANES;
  localparam int BW    = $clog2(BEATS);

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_e;

  function automatic logic [5:0] addr_of(input logic mode, input logic [5:0] scan);
    return mode ? scan : ZZ[scan];
  endfunction

  bank_e                              bank_q [2];
  bank_e                              bank_d [2];
  logic [ZIG_IN_WIDTH-1:0]            mem_q  [2][64];
  logic                               mode_q [2];
  logic                               wr_ptr_q, rd_ptr_q, iss_ptr_q;
  logic                               filling_q;
  logic [2:0]                         row_q;
  logic [BW-1:0]                      beat_q;
  logic                               free_q, ovf_q, vld_q, first_q, last_q;
  logic [ZIG_OUT_WIDTH*OUT_LANES-1:0] out_q, out_d;

  logic       hs_s, done_s, wr_free_s, accept_s, drop_s, issue_s, iss_last_s, row_last_s, wr_en_s;
  logic [2:0] wrow_s;

  // Handshake, fill and issue decisions; a bank freed this cycle may take a go.
  always_comb begin
    hs_s       = vld_q & zig_rdy_i;
    done_s     = hs_s & last_q;
    wr_free_s  = (bank_q[wr_ptr_q] == B_EMPTY) | (done_s & (rd_ptr_q == wr_ptr_q));
    accept_s   = zig_go_i & ~filling_q & wr_free_s;
    drop_s     = zig_go_i & ~filling_q & ~wr_free_s;
    row_last_s = filling_q & (row_q == 3'd7);
    wr_en_s    = accept_s | filling_q;
    wrow_s     = accept_s ? 3'd0 : row_q;
    issue_s    = (bank_q[iss_ptr_q] == B_DRAINING) & (~vld_q | zig_rdy_i);
    iss_last_s = (beat_q == BW'(BEATS - 1));
  end

  // Per-bank state transitions.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (accept_s && (wr_ptr_q == 1'(i))) begin
        bank_d[i] = B_FILLING;
      end else if (row_last_s && (wr_ptr_q == 1'(i))) begin
        bank_d[i] = B_FULL;
      end else if (done_s && (rd_ptr_q == 1'(i))) begin
        bank_d[i] = B_EMPTY;
      end else if (bank_q[i] == B_FULL) begin
        bank_d[i] = B_DRAINING;
      end else begin
        bank_d[i] = bank_q[i];
      end
    end
  end

  // Gather the lanes of the beat being issued, sign-extended to the output width.
  always_comb begin
    out_d = '0;
    for (int k = 0; k < OUT_LANES; k++) begin
      out_d[k*ZIG_OUT_WIDTH +: ZIG_OUT_WIDTH] = ZIG_OUT_WIDTH'($signed(
        mem_q[iss_ptr_q][addr_of(mode_q[iss_ptr_q], 6'(int'(beat_q) * OUT_LANES + k))]));
    end
  end

  // Coefficient storage; one full row lands per cycle, no reset needed for data.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int c = 0; c < 8; c++) begin
        mem_q[wr_ptr_q][{wrow_s, 3'(c)}] <= zig_in_i[c*ZIG_IN_WIDTH +: ZIG_IN_WIDTH];
      end
    end
  end

  // Control state and the registered output beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q[0] <= B_EMPTY;
      bank_q[1] <= B_EMPTY;
      mode_q[0] <= 1'b0;
      mode_q[1] <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      iss_ptr_q <= 1'b0;
      filling_q <= 1'b0;
      row_q     <= 3'd0;
      beat_q    <= '0;
      free_q    <= 1'b1;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      free_q    <= (bank_d[0] == B_EMPTY) | (bank_d[1] == B_EMPTY);
      ovf_q     <= ovf_q | drop_s;
      if (accept_s) begin
        mode_q[wr_ptr_q] <= zig_mode_i;
        filling_q        <= 1'b1;
        row_q            <= 3'd1;
      end else if (filling_q) begin
        filling_q <= ~row_last_s;
        row_q     <= row_q + 3'd1;
      end
      if (row_last_s) wr_ptr_q <= ~wr_ptr_q;
      if (done_s)     rd_ptr_q <= ~rd_ptr_q;
      // The issue pointer runs one beat ahead of the read pointer, so a FULL
      // bank starts the cycle after the previous bank's last beat is loaded.
      if (issue_s) begin
        beat_q  <= iss_last_s ? '0 : beat_q + BW'(1);
        if (iss_last_s) iss_ptr_q <= ~iss_ptr_q;
        vld_q   <= 1'b1;
        out_q   <= out_d;
        first_q <= (beat_q == '0);
        last_q  <= iss_last_s;
      end else if (hs_s) begin
        vld_q   <= 1'b0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

`ifdef ZIGZAG_EOB_EN
  logic [6:0] eob_q [2];
  logic [6:0] eob_o_q, row_eob_s;
  logic       wr_mode_s;

  function automatic logic [5:0] scan_of(input logic mode, input logic [5:0] raster);
    logic [5:0] p;
    p = raster;
    if (!mode) begin
      for (int s = 0; s < 64; s++) begin
        if (ZZ[s] == raster) p = 6'(s);
      end
    end
    return p;
  endfunction

  // Highest non-zero scan position (+1) within the row being written.
  always_comb begin
    wr_mode_s = accept_s ? zig_mode_i : mode_q[wr_ptr_q];
    row_eob_s = 7'd0;
    for (int c = 0; c < 8; c++) begin
      if ((zig_in_i[c*ZIG_IN_WIDTH +: ZIG_IN_WIDTH] != '0) &&
          ({1'b0, scan_of(wr_mode_s, {wrow_s, 3'(c)})} + 7'd1 > row_eob_s)) begin
        row_eob_s = {1'b0, scan_of(wr_mode_s, {wrow_s, 3'(c)})} + 7'd1;
      end else begin
        row_eob_s = row_eob_s;
      end
    end
  end

  // Per-bank end-of-block tracking and its output copy held across the block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      eob_q[0] <= 7'd0;
      eob_q[1] <= 7'd0;
      eob_o_q  <= 7'd0;
    end else begin
      if (accept_s) begin
        eob_q[wr_ptr_q] <= row_eob_s;
      end else if (filling_q && (row_eob_s > eob_q[wr_ptr_q])) begin
        eob_q[wr_ptr_q] <= row_eob_s;
      end
      if (issue_s) begin
        eob_o_q <= eob_q[iss_ptr_q];
      end else if (hs_s) begin
        eob_o_q <= 7'd0;
      end
    end
  end

  assign zig_eob_o = eob_o_q;
`endif

  assign zig_free_o  = free_q;
  assign zig_ovf_o   = ovf_q;
  assign zig_vld_o   = vld_q;
  assign zig_out_o   = out_q;
  assign zig_first_o = first_q;
  assign zig_last_o  = last_q;

endmodule

// File: tb/tb_zigzag_pp.sv
// Scoreboard bench for zigzag_pp: one instance with 1 lane, one with 8 lanes, checked
// against a diagonal-walk scan model; end-of-block checks compile in with ZIGZAG_EOB_EN.
module tb_zigzag_pp;
  localparam int IW = 16;
  localparam int OW = 16;

  typedef struct {
    logic [OW*8-1:0] data;
    logic            first;
    logic            last;
    logic [6:0]      eob;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            go1, mode1, free1, ovf1, vld1, rdy1, first1, last1;
  logic [IW*8-1:0] in1;
  logic [OW-1:0]   out1;
  logic            go8, mode8, free8, ovf8, vld8, rdy8, first8, last8;
  logic [IW*8-1:0] in8;
  logic [OW*8-1:0] out8;
`ifdef ZIGZAG_EOB_EN
  logic [6:0]      eob1, eob8;
`endif

  logic rdy_rand1, rdy_force1, rnd1, rdy8_f;
  always_comb rdy1 = rdy_rand1 ? rnd1 : rdy_force1;
  always_comb rdy8 = rdy8_f;
  always @(posedge clk) rnd1 <= ($urandom_range(0, 3) != 0);

  zigzag_pp #(.ZIG_IN_WIDTH(IW), .ZIG_OUT_WIDTH(OW), .OUT_LANES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .zig_go_i(go1), .zig_mode_i(mode1), .zig_in_i(in1),
    .zig_free_o(free1), .zig_ovf_o(ovf1), .zig_vld_o(vld1), .zig_rdy_i(rdy1),
    .zig_out_o(out1), .zig_first_o(first1), .zig_last_o(last1)
`ifdef ZIGZAG_EOB_EN
    , .zig_eob_o(eob1)
`endif
  );

  zigzag_pp #(.ZIG_IN_WIDTH(IW), .ZIG_OUT_WIDTH(OW), .OUT_LANES(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .zig_go_i(go8), .zig_mode_i(mode8), .zig_in_i(in8),
    .zig_free_o(free8), .zig_ovf_o(ovf8), .zig_vld_o(vld8), .zig_rdy_i(rdy8),
    .zig_out_o(out8), .zig_first_o(first8), .zig_last_o(last8)
`ifdef ZIGZAG_EOB_EN
    , .zig_eob_o(eob8)
`endif
  );

  int    n_chk = 0, n_fail = 0;
  int    cyc = 0;
  int    zz_scan [64];
  beat_t q1 [$];
  beat_t q8 [$];
  int    pops1 = 0, done1 = 0, acc1 = 0;
  int    run8 = 0, max_run8 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 1-lane instance: compare against the queue head every valid cycle.
  always @(negedge clk) begin
    if (!rst && vld1) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_beat1: valid beat %0h with empty scoreboard", out1);
      end else begin
        chk("data1", out1, q1[0].data[OW-1:0]);
        chk("first1", first1, q1[0].first);
        chk("last1", last1, q1[0].last);
`ifdef ZIGZAG_EOB_EN
        chk("eob1", eob1, q1[0].eob);
`endif
        if (rdy1) begin
          if (q1[0].last) done1++;
          void'(q1.pop_front());
          pops1++;
        end
      end
    end
  end

  // Monitor for the 8-lane instance, also tracking the longest run of valid cycles.
  always @(negedge clk) begin
    if (vld8) run8 = run8 + 1;
    else      run8 = 0;
    if (run8 > max_run8) max_run8 = run8;
    if (!rst && vld8) begin
      if (q8.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_beat8: valid beat %0h with empty scoreboard", out8);
      end else begin
        chk("data8", out8, q8[0].data);
        chk("first8", first8, q8[0].first);
        chk("last8", last8, q8[0].last);
`ifdef ZIGZAG_EOB_EN
        chk("eob8", eob8, q8[0].eob);
`endif
        if (rdy8) void'(q8.pop_front());
      end
    end
  end

  // Reference model: expected beats of one block in scan order.
  task automatic push_block(input int L, input int coef [64], input bit mode);
    int    order [64];
    int    e;
    beat_t bt;
    e = 0;
    for (int s = 0; s < 64; s++) order[s] = mode ? s : zz_scan[s];
    for (int s = 0; s < 64; s++) if (coef[order[s]] != 0) e = s + 1;
    for (int b = 0; b < 64 / L; b++) begin
      bt.data = '0;
      for (int k = 0; k < L; k++) bt.data[k*OW +: OW] = OW'(coef[order[b*L+k]]);
      bt.first = (b == 0);
      bt.last  = (b == 64 / L - 1);
      bt.eob   = 7'(e);
      if (L == 1) q1.push_back(bt);
      else        q8.push_back(bt);
    end
  endtask

  task automatic send_block(input int L, input int coef [64], input bit mode, input bit expect_acc);
    logic [IW*8-1:0] row;
    if (expect_acc) begin
      push_block(L, coef, mode);
      if (L == 1) acc1++;
    end
    for (int r = 0; r < 8; r++) begin
      row = '0;
      for (int c = 0; c < 8; c++) row[c*IW +: IW] = IW'(coef[r*8+c]);
      if (L == 1) begin go1 = (r == 0); mode1 = mode; in1 = row; end
      else        begin go8 = (r == 0); mode8 = mode; in8 = row; end
      tick();
    end
    go1 = 1'b0;
    go8 = 1'b0;
  endtask

  task automatic rand_block(output int coef [64]);
    for (int i = 0; i < 64; i++)
      coef[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 65535)) - 32768 : 0;
  endtask

  task automatic wait_drain(input int L, input string nm);
    int n;
    n = 0;
    while (((L == 1) ? q1.size() : q8.size()) != 0 && n < 4000) begin
      tick();
      n++;
    end
    chk(nm, (L == 1) ? q1.size() : q8.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int coef [64];
    int ramp [64];
    int idx, gc, base, n;
    idx = 0;
    for (int d = 0; d < 15; d++) begin
      for (int j = 0; j < 8; j++) begin
        int r, c;
        r = (d % 2 == 0) ? 7 - j : j;
        c = d - r;
        if (c >= 0 && c < 8) begin
          zz_scan[idx] = r * 8 + c;
          idx++;
        end
      end
    end
    for (int i = 0; i < 64; i++) ramp[i] = i;

    rst = 1'b1; go1 = 1'b0; go8 = 1'b0; mode1 = 1'b0; mode8 = 1'b0; in1 = '0; in8 = '0;
    rdy_rand1 = 1'b0; rdy_force1 = 1'b1; rdy8_f = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_vld1", vld1, 0);   chk("rst_free1", free1, 1); chk("rst_ovf1", ovf1, 0);
    chk("rst_first1", first1, 0); chk("rst_last1", last1, 0); chk("rst_out1", out1, 0);
    chk("rst_vld8", vld8, 0);   chk("rst_free8", free8, 1); chk("rst_out8", out8, 0);
`ifdef ZIGZAG_EOB_EN
    chk("rst_eob1", eob1, 0);
`endif

    // Zigzag ramp, 1 lane, with first-beat latency.
    gc = cyc + 1;
    send_block(1, ramp, 1'b0, 1'b1);
    n = 0;
    while (!vld1 && n < 20) begin @(negedge clk); n++; end
    chk("latency_go_to_beat0", cyc - gc, 9);
    wait_drain(1, "drain_zigzag_ramp");

    // Raster ramp.
    send_block(1, ramp, 1'b1, 1'b1);
    wait_drain(1, "drain_raster_ramp");

    // 8 lanes, two back-to-back blocks: 16 valid beats without a gap.
    rand_block(coef);
    send_block(8, ramp, 1'b0, 1'b1);
    send_block(8, coef, 1'b1, 1'b1);
    wait_drain(8, "drain_lanes8_pair");
    chk("lanes8_no_gap_run", max_run8, 16);
    chk("lanes8_ovf", ovf8, 0);

    // 8 lanes with a stall in the middle of the drain.
    rand_block(coef);
    send_block(8, coef, 1'b0, 1'b1);
    repeat (3) tick();
    rdy8_f = 1'b0;
    repeat (5) tick();
    rdy8_f = 1'b1;
    wait_drain(8, "drain_lanes8_stall");

    // Overflow: ready low across three go pulses 8 cycles apart.
    rdy_force1 = 1'b0;
    rand_block(coef);
    send_block(1, coef, 1'b0, 1'b1);
    rand_block(coef);
    send_block(1, coef, 1'b1, 1'b1);
    rand_block(coef);
    send_block(1, coef, 1'b0, 1'b0);
    chk("ovf_set", ovf1, 1);
    chk("ovf_free_low", free1, 0);
    rdy_rand1 = 1'b1;
    wait_drain(1, "drain_after_ovf");
    rdy_rand1 = 1'b0;
    rdy_force1 = 1'b1;
    chk("ovf_sticky", ovf1, 1);

    // Reset during beat 20 of a drain.
    rand_block(coef);
    base = pops1;
    send_block(1, coef, 1'b0, 1'b1);
    n = 0;
    while (pops1 - base < 20 && n < 200) begin tick(); n++; end
    chk("reached_beat20", pops1 - base, 20);
    rdy_force1 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q1.delete();
    acc1 = done1;
    chk("midrst_vld", vld1, 0);
    chk("midrst_free", free1, 1);
    chk("midrst_ovf", ovf1, 0);
    rdy_force1 = 1'b1;
    rand_block(coef);
    send_block(1, coef, 1'b1, 1'b1);
    wait_drain(1, "drain_after_reset");

    // Random blocks and modes with random ready; go only when the model has a free bank.
    rdy_rand1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (acc1 - done1 >= 2 && n < 4000) begin tick(); n++; end
      chk("free_before_go", free1, 1);
      rand_block(coef);
      send_block(1, coef, 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain(1, "drain_random");
    rdy_rand1 = 1'b0;

`ifdef ZIGZAG_EOB_EN
    // End-of-block: two non-zero coefficients, the furthest at scan position 11.
    for (int i = 0; i < 64; i++) coef[i] = 0;
    coef[0] = 5;
    coef[zz_scan[11]] = -3;
    send_block(1, coef, 1'b0, 1'b1);
    wait_drain(1, "drain_eob12");
    for (int i = 0; i < 64; i++) coef[i] = 0;
    send_block(1, coef, 1'b0, 1'b1);
    send_block(8, coef, 1'b1, 1'b1);
    wait_drain(1, "drain_eob0");
    wait_drain(8, "drain_eob0_lanes8");
    chk("eob_idle", eob1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
